// File: rtl/data_mem_responder.sv
//==============================================================================
// Module   : data_mem_responder
// Purpose  : MEM-stage data-memory responder. It accepts one load or store at a
//            time, waits WAIT_CYCLES cycles, and then returns extended load data
//            or a store acknowledgement.
// Options  : DMEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
//            Without it, these accesses are force-aligned.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         ADDR_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] index;
    logic [1:0]        lane;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       rword;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic              access;

    // The first RESP cycle, before rsp_valid rises, is the single access cycle.
    assign access = (state == ST_RESP) && !rsp_valid;

    always_comb begin
        index = addr_q[ADDR_W+1:2];
        err   = (addr_q[31:ADDR_W+2] != '0) || (size_q == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (((size_q == 2'd1) && addr_q[0]) || ((size_q == 2'd2) && (addr_q[1:0] != 2'b00)))
            err = 1'b1;
`endif
        lane  = addr_q[1:0];
        be    = 4'b1111;
        wlane = wdata_q;
        case (size_q)
            2'd0: begin
                be    = 4'b0001 << lane;
                wlane = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane  = {addr_q[1], 1'b0};
                be    = 4'b0011 << lane;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                lane  = 2'b00;
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
        rword   = mem[index];
        shifted = rword >> {lane, 3'b000};
        case (size_q)
            2'd0:    load_data = unsigned_q ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = unsigned_q ? {16'd0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // The storage array is intentionally left without a reset.
    always_ff @(posedge clock) begin
        if (access && we_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[index][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        if (WAIT_CYCLES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= ST_RESP;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || we_q) ? 32'd0 : load_data;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//==============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder.
//            It uses a byte-level reference memory and directed transactions.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a little-endian byte memory with one outstanding response.
    logic [7:0]  mem_b [DEPTH*4];
    bit          known [DEPTH*4];
    bit          pending = 0, applied = 0, p_skip = 0, prev_rst = 1;
    bit          p_we = 0, p_err = 0;
    int          due = 0, p_nb = 0;
    logic [31:0] p_a = 0, p_wdata = 0, p_rd = 0;

    always @(negedge clock) begin
        if (!reset) begin
            pending  = 0;
            prev_rst = 1;
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        end else begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !pending && !prev_rst});
            if (pending && cyc >= due) begin
                chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_err",   {31'd0, rsp_err},   {31'd0, p_err});
                if (!p_skip) chk("rsp_rdata", rsp_rdata, p_rd);
                if (!applied && p_we && !p_err) begin
                    for (int i = 0; i < p_nb; i++) begin
                        mem_b[p_a+i] = p_wdata[8*i +: 8];
                        known[p_a+i] = 1;
                    end
                end
                applied = 1;
                if (rsp_ready) pending = 0;
            end else begin
                chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                chk("idle_rsp_rdata", rsp_rdata, 32'd0);
                chk("idle_rsp_err",   {31'd0, rsp_err},   32'd0);
            end
            if (req_valid && req_ready) begin
                p_err = (req_addr >= 32'(DEPTH*4)) || (req_size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
                if ((req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00))
                    p_err = 1;
`endif
                p_a = (req_size == 2'd1) ? (req_addr & ~32'd1) :
                      (req_size == 2'd2) ? (req_addr & ~32'd3) : req_addr;
                p_nb    = 1 << req_size;
                p_we    = req_we;
                p_wdata = req_wdata;
                p_rd    = 0;
                p_skip  = 0;
                if (!p_err && !req_we) begin
                    for (int i = 0; i < p_nb; i++) begin
                        if (!known[p_a+i]) p_skip = 1;
                        p_rd = p_rd | (32'(mem_b[p_a+i]) << (8*i));
                    end
                    if (!req_unsigned && p_nb == 1) p_rd = {{24{p_rd[7]}}, p_rd[7:0]};
                    if (!req_unsigned && p_nb == 2) p_rd = {{16{p_rd[15]}}, p_rd[15:0]};
                end
                pending = 1;
                applied = 0;
                due     = cyc + W + 2;
            end
            prev_rst = 0;
        end
    end

    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic err, output int lat, output int acc);
        int n;
        rsp_ready    = (hold == 0);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        acc          = cyc;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        lat = 0;
        @(negedge clock);
        while (!rsp_valid && lat < 50) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        rd  = rsp_rdata;
        err = rsp_err;
        if (hold > 0) begin
            repeat (hold) @(negedge clock);
            @(posedge clock);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, a0, a1, a2;

    initial begin
        for (int i = 0; i < DEPTH*4; i++) known[i] = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("lit_reset_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Word store followed by a load from the same address.
        xact(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, a0);
        chk("lit_sw_rdata", rd, 32'd0);
        xact(0, 2, 0, 32'h10, 32'h0, 0, rd, er, lat, a0);
        chk("lit_lw_10", rd, 32'hDEADBEEF);
        chk("lit_latency", lat, W + 1);

        // Byte lane merge with sign and zero extension.
        xact(1, 2, 0, 32'h20, 32'h0, 0, rd, er, lat, a0);
        xact(1, 0, 0, 32'h21, 32'h80, 0, rd, er, lat, a0);
        xact(0, 0, 0, 32'h21, 32'h0, 0, rd, er, lat, a0);
        chk("lit_lb_21", rd, 32'hFFFFFF80);
        xact(0, 0, 1, 32'h21, 32'h0, 0, rd, er, lat, a0);
        chk("lit_lbu_21", rd, 32'h00000080);
        xact(0, 2, 0, 32'h20, 32'h0, 0, rd, er, lat, a0);
        chk("lit_lw_20", rd, 32'h00008000);
        xact(0, 1, 0, 32'h20, 32'h0, 0, rd, er, lat, a0);
        chk("lit_lh_20", rd, 32'hFFFF8000);
        xact(1, 2, 0, 32'h30, 32'h0, 0, rd, er, lat, a0);
        xact(1, 1, 0, 32'h32, 32'h1234BEEF, 0, rd, er, lat, a0);
        xact(0, 2, 0, 32'h30, 32'h0, 0, rd, er, lat, a0);
        chk("lit_sh_lane", rd, 32'hBEEF0000);

        // Out-of-range and illegal-size accesses must fault without writing.
        xact(1, 2, 0, 32'h0, 32'h01020304, 0, rd, er, lat, a0);
        xact(0, 2, 0, 32'(DEPTH*4), 32'h0, 0, rd, er, lat, a0);
        chk("lit_oor_err", {31'd0, er}, 32'd1);
        chk("lit_oor_rdata", rd, 32'd0);
        xact(1, 2, 0, 32'(DEPTH*4), 32'hAAAAAAAA, 0, rd, er, lat, a0);
        chk("lit_oor_st_err", {31'd0, er}, 32'd1);
        xact(1, 3, 0, 32'h20, 32'hFFFFFFFF, 0, rd, er, lat, a0);
        chk("lit_size3_err", {31'd0, er}, 32'd1);
        xact(0, 2, 0, 32'h0, 32'h0, 0, rd, er, lat, a0);
        chk("lit_word0_kept", rd, 32'h01020304);
        xact(0, 2, 0, 32'h20, 32'h0, 0, rd, er, lat, a0);
        chk("lit_word20_kept", rd, 32'h00008000);

        // Misaligned word access.
        xact(0, 2, 0, 32'h22, 32'h0, 0, rd, er, lat, a0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lit_mis_err", {31'd0, er}, 32'd1);
        chk("lit_mis_rdata", rd, 32'd0);
`else
        chk("lit_mis_err", {31'd0, er}, 32'd0);
        chk("lit_mis_rdata", rd, 32'h00008000);
`endif

        // Back-pressure hold, then back-to-back requests. A retire blocks accept for
        // one cycle, so the accepts are W+3 edges apart.
        xact(0, 2, 0, 32'h10, 32'h0, 5, rd, er, lat, a0);
        chk("lit_hold_rdata", rd, 32'hDEADBEEF);
        xact(0, 2, 0, 32'h10, 32'h0, 0, rd, er, lat, a0);
        xact(0, 2, 0, 32'h20, 32'h0, 0, rd, er, lat, a1);
        xact(0, 2, 0, 32'h30, 32'h0, 0, rd, er, lat, a2);
        chk("lit_b2b_gap1", a1 - a0, W + 3);
        chk("lit_b2b_gap2", a2 - a1, W + 3);

        // Reset during the wait of a store; that store must be lost.
        xact(1, 2, 0, 32'h40, 32'h11111111, 0, rd, er, lat, a0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h40;
        req_wdata = 32'h22222222;
        @(negedge clock);
        chk("lit_pre_rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("lit_rel_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clock);
        chk("lit_rel_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        xact(0, 2, 0, 32'h40, 32'h0, 0, rd, er, lat, a0);
        chk("lit_dropped_store", rd, 32'h11111111);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
